regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
// - Shares the register file's single write port between two writeback requesters (req0: ALU path, req1: load/long-latency path).
// - Holds a pending-write scoreboard so issue logic can detect RAW hazards (busy query) and WAW stalls (issue_ready_o).
// - Sits between the writeback sources and the register file write port; its outputs drive write_enable/address/data directly.
// PARAMETERS
// - XLEN            32  data width of a register
// - REG_ADDR_WIDTH  5   register address width; 2**REG_ADDR_WIDTH registers, x0 hardwired zero
// PORTS
// - clk_i              in   1               single clock; all state updates on posedge
// - rst_i              in   1               reset, synchronous, active-high
// - reqN_valid_i       in   1               (N=0,1) writeback request valid
// - reqN_ready_o       out  1               (N=0,1) grant; accept = valid & ready
// - reqN_addr_i        in   REG_ADDR_WIDTH  (N=0,1) destination register
// - reqN_data_i        in   XLEN            (N=0,1) write data
// - issue_valid_i      in   1               instruction with destination issuing
// - issue_addr_i       in   REG_ADDR_WIDTH  its destination register
// - issue_ready_o      out  1               0 = destination already pending (WAW stall)
// - query_addr_M_i     in   REG_ADDR_WIDTH  (M=1,2) source register to check
// - busy_M_o           out  1               (M=1,2) source has a pending write
// - rf_write_enable_o  out  1               to register file write enable
// - rf_write_address_o out  REG_ADDR_WIDTH  to register file write address
// - rf_write_data_o    out  XLEN            to register file write data
// BEHAVIOUR
// - Reset (rst_i=1 at posedge): busy[] all 0, priority -> req0, rf_write_* all 0. While rst_i=1, reqN_ready_o=0 and issue_ready_o=0.
// - Arbitration (comb): at most one ready per cycle. Only one valid -> it gets ready. Both valid -> priority holder gets ready.
// - Round-robin: after any accept, priority moves to the other requester; no accept -> priority unchanged.
// - Requester holds valid/addr/data stable until accepted; valid deasserted without accept is legal (no state change).
// - Write port: registered, latency 1. Cycle after accept: rf_write_enable_o=1, address/data = accepted values.
//   Other cycles: enable=0, address/data hold last value. Register file captures on the negedge of that cycle.
// - Accept with addr 0: consumes grant and moves priority, but next-cycle rf_write_enable_o=0 (address/data still update).
// - Scoreboard: busy[1..2**REG_ADDR_WIDTH-1], busy[0] constant 0.
//   - issue_ready_o = ~busy[issue_addr_i] (comb; 1 for addr 0). Issue accept (valid & ready) sets busy[addr] at posedge.
//   - Writeback accept clears busy[addr] at the same posedge that loads rf_write_*.
//   - Same-edge set and clear of the same address: set wins (new issue outstanding).
//   - Writeback to a non-busy register is legal; clear is a no-op.
// - busy_M_o = busy[query_addr_M_i] (comb, 0 for addr 0). Busy drops in the cycle the write is on rf_write_*; comb read
//   after that negedge returns new data, so RAW is safe with no extra cycle.
// - Reset mid-operation: pending accept discarded, no write emitted, all busy bits lost; sources must re-issue.
// CONFIGURATION
// - REGFILE_WB_BYPASS_EN defined: adds ports bypass_hit_M_o (1) and bypass_data_M_o (XLEN), M=1,2.
//   bypass_hit_M_o=1 when a writeback is accepted this cycle with addr == query_addr_M_i != 0; bypass_data_M_o = its data
//   (0 when no hit). busy_M_o forced 0 on hit, so consumer takes data a cycle early.
// - Not defined: bypass ports absent; busy_M_o reflects registered scoreboard only.
// TESTING
// - Reset: rst_i=1 two cycles with both reqs valid -> readies 0, rf_write_enable_o=0, busy_1_o=0 for all query addrs.
// - Single write: req0 valid addr 5 data 0xDEADBEEF -> req0_ready_o=1 same cycle; next cycle enable=1 addr 5 data 0xDEADBEEF; then enable=0.
// - Contention: both valid 4 cycles (req0 addr 3, req1 addr 7) -> grants req0,req1,req0,req1; rf writes 3,7,3,7 one cycle later.
// - Scoreboard: issue addr 9 -> busy_1_o=1 (query 9) next cycle; issue addr 9 again -> issue_ready_o=0; req1 writes 9 -> busy 0 and issue_ready_o=1 next cycle.
// - x0 and reset: req1 addr 0 -> ready 1, next cycle enable 0; issue addr 0 never busy; busy[12] set then rst_i pulse -> busy_2_o=0.
// - Bypass: req0 addr 9 data 0x55 accepted while query_addr_1_i=9 busy -> with macro hit=1 data 0x55 busy_1_o=0; without busy_1_o=1.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback, issue, query and register-file write-port signals of regfile_wb_arbiter.
// Bypass ports exist only when REGFILE_WB_BYPASS_EN is defined.
interface regfile_wb_arbiter_if #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      req0_valid_i;
    logic                      req0_ready_o;
    logic [REG_ADDR_WIDTH-1:0] req0_addr_i;
    logic [XLEN-1:0]           req0_data_i;
    logic                      req1_valid_i;
    logic                      req1_ready_o;
    logic [REG_ADDR_WIDTH-1:0] req1_addr_i;
    logic [XLEN-1:0]           req1_data_i;
    logic                      issue_valid_i;
    logic [REG_ADDR_WIDTH-1:0] issue_addr_i;
    logic                      issue_ready_o;
    logic [REG_ADDR_WIDTH-1:0] query_addr_1_i;
    logic [REG_ADDR_WIDTH-1:0] query_addr_2_i;
    logic                      busy_1_o;
    logic                      busy_2_o;
    logic                      rf_write_enable_o;
    logic [REG_ADDR_WIDTH-1:0] rf_write_address_o;
    logic [XLEN-1:0]           rf_write_data_o;
`ifdef REGFILE_WB_BYPASS_EN
    logic                      bypass_hit_1_o;
    logic                      bypass_hit_2_o;
    logic [XLEN-1:0]           bypass_data_1_o;
    logic [XLEN-1:0]           bypass_data_2_o;
`endif

    modport slave (
        input  req0_valid_i, req0_addr_i, req0_data_i,
        input  req1_valid_i, req1_addr_i, req1_data_i,
        input  issue_valid_i, issue_addr_i, query_addr_1_i, query_addr_2_i,
        output req0_ready_o, req1_ready_o, issue_ready_o, busy_1_o, busy_2_o,
        output rf_write_enable_o, rf_write_address_o, rf_write_data_o
`ifdef REGFILE_WB_BYPASS_EN
        , output bypass_hit_1_o, bypass_hit_2_o, bypass_data_1_o, bypass_data_2_o
`endif
    );

    modport master (
        output req0_valid_i, req0_addr_i, req0_data_i,
        output req1_valid_i, req1_addr_i, req1_data_i,
        output issue_valid_i, issue_addr_i, query_addr_1_i, query_addr_2_i,
        input  req0_ready_o, req1_ready_o, issue_ready_o, busy_1_o, busy_2_o,
        input  rf_write_enable_o, rf_write_address_o, rf_write_data_o
`ifdef REGFILE_WB_BYPASS_EN
        , input bypass_hit_1_o, bypass_hit_2_o, bypass_data_1_o, bypass_data_2_o
`endif
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port plus pending-write scoreboard.
// Define REGFILE_WB_BYPASS_EN to add same-cycle writeback bypass outputs.
module regfile_wb_arbiter #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    regfile_wb_arbiter_if.slave   bus
);
    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    typedef enum logic {PRIO_REQ0, PRIO_REQ1} prio_t;

    prio_t                     prio_q;
    logic [NUM_REGS-1:0]       busy_q;
    logic [NUM_REGS-1:0]       busy_next;
    logic                      rf_we_q;
    logic [REG_ADDR_WIDTH-1:0] rf_addr_q;
    logic [XLEN-1:0]           rf_data_q;

    logic                      grant0;
    logic                      grant1;
    logic                      wb_accept;
    logic [REG_ADDR_WIDTH-1:0] wb_addr;
    logic [XLEN-1:0]           wb_data;
    logic                      issue_ready;
    logic                      issue_accept;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst_i) begin
            if (bus.req0_valid_i && bus.req1_valid_i) begin
                grant0 = (prio_q == PRIO_REQ0);
                grant1 = (prio_q == PRIO_REQ1);
            end else begin
                grant0 = bus.req0_valid_i;
                grant1 = bus.req1_valid_i;
            end
        end
        wb_accept = grant0 | grant1;
        wb_addr   = grant1 ? bus.req1_addr_i : bus.req0_addr_i;
        wb_data   = grant1 ? bus.req1_data_i : bus.req0_data_i;
    end

    assign issue_ready  = !rst_i && !busy_q[bus.issue_addr_i];
    assign issue_accept = bus.issue_valid_i && issue_ready;

    // Clear before set so a same-edge issue to the written register stays outstanding.
    always_comb begin
        busy_next = busy_q;
        if (wb_accept) begin
            busy_next[wb_addr] = 1'b0;
        end
        if (issue_accept) begin
            busy_next[bus.issue_addr_i] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q    <= PRIO_REQ0;
            busy_q    <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            busy_q  <= busy_next;
            rf_we_q <= wb_accept && (wb_addr != '0);
            if (wb_accept) begin
                rf_addr_q <= wb_addr;
                rf_data_q <= wb_data;
                prio_q    <= grant0 ? PRIO_REQ1 : PRIO_REQ0;
            end
        end
    end

    assign bus.req0_ready_o       = grant0;
    assign bus.req1_ready_o       = grant1;
    assign bus.issue_ready_o      = issue_ready;
    assign bus.rf_write_enable_o  = rf_we_q;
    assign bus.rf_write_address_o = rf_addr_q;
    assign bus.rf_write_data_o    = rf_data_q;

`ifdef REGFILE_WB_BYPASS_EN
    logic hit1;
    logic hit2;

    assign hit1 = wb_accept && (wb_addr == bus.query_addr_1_i) && (bus.query_addr_1_i != '0);
    assign hit2 = wb_accept && (wb_addr == bus.query_addr_2_i) && (bus.query_addr_2_i != '0);

    assign bus.bypass_hit_1_o  = hit1;
    assign bus.bypass_hit_2_o  = hit2;
    assign bus.bypass_data_1_o = hit1 ? wb_data : '0;
    assign bus.bypass_data_2_o = hit2 ? wb_data : '0;
    assign bus.busy_1_o        = busy_q[bus.query_addr_1_i] && !hit1;
    assign bus.busy_2_o        = busy_q[bus.query_addr_2_i] && !hit2;
`else
    assign bus.busy_1_o = busy_q[bus.query_addr_1_i];
    assign bus.busy_2_o = busy_q[bus.query_addr_2_i];
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter: arbitration, write port timing, scoreboard, x0, reset, bypass.
module tb_regfile_wb_arbiter;
    logic clk_i = 1'b0;
    logic rst_i;

    int n_checks = 0;
    int n_errors = 0;

    regfile_wb_arbiter_if #(.XLEN(32), .REG_ADDR_WIDTH(5)) bus ();

    regfile_wb_arbiter #(.XLEN(32), .REG_ADDR_WIDTH(5)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic after_edge();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i              = 1'b1;
        bus.req0_valid_i   = 1'b1;
        bus.req0_addr_i    = 5'd3;
        bus.req0_data_i    = 32'h0;
        bus.req1_valid_i   = 1'b1;
        bus.req1_addr_i    = 5'd7;
        bus.req1_data_i    = 32'h0;
        bus.issue_valid_i  = 1'b0;
        bus.issue_addr_i   = 5'd0;
        bus.query_addr_1_i = 5'd0;
        bus.query_addr_2_i = 5'd0;

        // Reset held two cycles with both requesters valid
        @(negedge clk_i);
        check("rst_ready0", 64'(bus.req0_ready_o), 64'd0);
        check("rst_ready1", 64'(bus.req1_ready_o), 64'd0);
        check("rst_issue_ready", 64'(bus.issue_ready_o), 64'd0);
        after_edge();
        after_edge();
        check("rst_we", 64'(bus.rf_write_enable_o), 64'd0);
        check("rst_waddr", 64'(bus.rf_write_address_o), 64'd0);
        check("rst_wdata", 64'(bus.rf_write_data_o), 64'd0);
        for (int q = 0; q < 32; q++) begin
            bus.query_addr_1_i = 5'(q);
            #1;
            check("rst_busy1", 64'(bus.busy_1_o), 64'd0);
        end
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        rst_i            = 1'b0;

        // Single write through req0
        bus.req0_valid_i = 1'b1;
        bus.req0_addr_i  = 5'd5;
        bus.req0_data_i  = 32'hDEADBEEF;
        @(negedge clk_i);
        check("single_ready0", 64'(bus.req0_ready_o), 64'd1);
        check("single_ready1", 64'(bus.req1_ready_o), 64'd0);
        after_edge();
        bus.req0_valid_i = 1'b0;
        check("single_we", 64'(bus.rf_write_enable_o), 64'd1);
        check("single_waddr", 64'(bus.rf_write_address_o), 64'd5);
        check("single_wdata", 64'(bus.rf_write_data_o), 64'hDEADBEEF);
        after_edge();
        check("single_we_off", 64'(bus.rf_write_enable_o), 64'd0);
        check("single_waddr_hold", 64'(bus.rf_write_address_o), 64'd5);
        check("single_wdata_hold", 64'(bus.rf_write_data_o), 64'hDEADBEEF);

        // Return priority to req0, then contend for four cycles
        rst_i = 1'b1;
        after_edge();
        rst_i = 1'b0;
        bus.req0_valid_i = 1'b1;
        bus.req0_addr_i  = 5'd3;
        bus.req0_data_i  = 32'h0000_0030;
        bus.req1_valid_i = 1'b1;
        bus.req1_addr_i  = 5'd7;
        bus.req1_data_i  = 32'h0000_0070;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("rr_ready0", 64'(bus.req0_ready_o), (i % 2 == 0) ? 64'd1 : 64'd0);
            check("rr_ready1", 64'(bus.req1_ready_o), (i % 2 == 0) ? 64'd0 : 64'd1);
            after_edge();
            check("rr_we", 64'(bus.rf_write_enable_o), 64'd1);
            check("rr_waddr", 64'(bus.rf_write_address_o), (i % 2 == 0) ? 64'd3 : 64'd7);
            check("rr_wdata", 64'(bus.rf_write_data_o), (i % 2 == 0) ? 64'h30 : 64'h70);
        end
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        after_edge();
        check("rr_we_off", 64'(bus.rf_write_enable_o), 64'd0);

        // Scoreboard set, WAW stall, clear by req1 writeback
        bus.query_addr_1_i = 5'd9;
        bus.issue_valid_i  = 1'b1;
        bus.issue_addr_i   = 5'd9;
        @(negedge clk_i);
        check("sb_issue_ready", 64'(bus.issue_ready_o), 64'd1);
        check("sb_busy_before", 64'(bus.busy_1_o), 64'd0);
        after_edge();
        check("sb_busy_set", 64'(bus.busy_1_o), 64'd1);
        @(negedge clk_i);
        check("sb_waw_stall", 64'(bus.issue_ready_o), 64'd0);
        after_edge();
        bus.issue_valid_i = 1'b0;
        check("sb_busy_held", 64'(bus.busy_1_o), 64'd1);
        bus.req1_valid_i = 1'b1;
        bus.req1_addr_i  = 5'd9;
        bus.req1_data_i  = 32'h0000_0099;
        @(negedge clk_i);
        check("sb_wb_ready1", 64'(bus.req1_ready_o), 64'd1);
        after_edge();
        bus.req1_valid_i = 1'b0;
        check("sb_busy_clear", 64'(bus.busy_1_o), 64'd0);
        check("sb_issue_ready_again", 64'(bus.issue_ready_o), 64'd1);
        check("sb_we", 64'(bus.rf_write_enable_o), 64'd1);
        check("sb_waddr", 64'(bus.rf_write_address_o), 64'd9);
        check("sb_wdata", 64'(bus.rf_write_data_o), 64'h99);

        // Writeback to x0 consumes the grant but does not write
        bus.req1_valid_i = 1'b1;
        bus.req1_addr_i  = 5'd0;
        bus.req1_data_i  = 32'h0000_1234;
        @(negedge clk_i);
        check("x0_ready1", 64'(bus.req1_ready_o), 64'd1);
        after_edge();
        bus.req1_valid_i = 1'b0;
        check("x0_we", 64'(bus.rf_write_enable_o), 64'd0);
        check("x0_waddr", 64'(bus.rf_write_address_o), 64'd0);
        check("x0_wdata", 64'(bus.rf_write_data_o), 64'h1234);
        bus.issue_valid_i = 1'b1;
        bus.issue_addr_i  = 5'd0;
        @(negedge clk_i);
        check("x0_issue_ready", 64'(bus.issue_ready_o), 64'd1);
        after_edge();
        check("x0_issue_ready_after", 64'(bus.issue_ready_o), 64'd1);
        bus.issue_valid_i  = 1'b0;
        bus.query_addr_1_i = 5'd0;
        #1;
        check("x0_busy", 64'(bus.busy_1_o), 64'd0);

        // Bypass: writeback accepted while the queried register is busy
        bus.issue_valid_i  = 1'b1;
        bus.issue_addr_i   = 5'd9;
        after_edge();
        bus.issue_valid_i  = 1'b0;
        bus.query_addr_1_i = 5'd9;
        bus.query_addr_2_i = 5'd4;
        #1;
        check("byp_busy_pre", 64'(bus.busy_1_o), 64'd1);
        bus.req0_valid_i = 1'b1;
        bus.req0_addr_i  = 5'd9;
        bus.req0_data_i  = 32'h0000_0055;
        @(negedge clk_i);
        check("byp_ready0", 64'(bus.req0_ready_o), 64'd1);
`ifdef REGFILE_WB_BYPASS_EN
        check("byp_hit1", 64'(bus.bypass_hit_1_o), 64'd1);
        check("byp_data1", 64'(bus.bypass_data_1_o), 64'h55);
        check("byp_busy1", 64'(bus.busy_1_o), 64'd0);
        check("byp_hit2", 64'(bus.bypass_hit_2_o), 64'd0);
        check("byp_data2", 64'(bus.bypass_data_2_o), 64'h0);
`else
        check("byp_busy1", 64'(bus.busy_1_o), 64'd1);
`endif
        after_edge();
        bus.req0_valid_i = 1'b0;
        check("byp_busy_after", 64'(bus.busy_1_o), 64'd0);

        // Same-edge issue and writeback of the same register: set wins
        bus.query_addr_1_i = 5'd20;
        bus.issue_valid_i  = 1'b1;
        bus.issue_addr_i   = 5'd20;
        bus.req0_valid_i   = 1'b1;
        bus.req0_addr_i    = 5'd20;
        bus.req0_data_i    = 32'h0000_0020;
        @(negedge clk_i);
        check("same_edge_ready0", 64'(bus.req0_ready_o), 64'd1);
        after_edge();
        bus.issue_valid_i = 1'b0;
        bus.req0_valid_i  = 1'b0;
        check("same_edge_busy", 64'(bus.busy_1_o), 64'd1);

        // Reset mid-operation drops pending accept and busy bits
        bus.issue_valid_i  = 1'b1;
        bus.issue_addr_i   = 5'd12;
        after_edge();
        bus.issue_valid_i  = 1'b0;
        bus.query_addr_2_i = 5'd12;
        #1;
        check("rst2_busy_pre", 64'(bus.busy_2_o), 64'd1);
        rst_i            = 1'b1;
        bus.req0_valid_i = 1'b1;
        bus.req0_addr_i  = 5'd5;
        bus.req0_data_i  = 32'h0000_0777;
        @(negedge clk_i);
        check("rst2_ready0", 64'(bus.req0_ready_o), 64'd0);
        after_edge();
        bus.req0_valid_i = 1'b0;
        rst_i            = 1'b0;
        check("rst2_busy2", 64'(bus.busy_2_o), 64'd0);
        check("rst2_busy1", 64'(bus.busy_1_o), 64'd0);
        check("rst2_we", 64'(bus.rf_write_enable_o), 64'd0);
        after_edge();
        check("rst2_we_after", 64'(bus.rf_write_enable_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
